aidan_mcnay_edge_detect_multi: RTL and testbench

AIDAN_MCNAY_EDGE_DETECT_MULTI -- requirements
Module: aidan_mcnay_edge_detect_multi

---
 rtl/aidan_mcnay_edge_detect_multi.sv | 124 ++++++++++++
 tb/tb_aidan_mcnay_edge_detect_multi.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aidan_mcnay_edge_detect_multi.sv
// aidan_mcnay_edge_detect_multi
// Multi-channel asynchronous input conditioner: per-channel synchroniser,
// optional debounce filter, mode-selectable edge detector and sticky
// pending/overflow event flags.
// Optional feature macro: AIDAN_MCNAY_EDGE_DETECT_DEBOUNCE_EN
//   defined   -> stable only follows sync after DEBOUNCE_CYCLES agreeing cycles
//   undefined -> stable follows sync every cycle, DEBOUNCE_CYCLES unused
module aidan_mcnay_edge_detect_multi #(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] in_signal,
    input  logic [1:0]        mode,
    input  logic [NUM_CH-1:0] clear,
    output logic [NUM_CH-1:0] pulse,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overflow,
    output logic [NUM_CH-1:0] stable
);

    // Reject nonsensical parameterisations at elaboration time
    if (NUM_CH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("aidan_mcnay_edge_detect_multi: illegal parameter value");
    end

    localparam logic [1:0] MODE_ANY     = 2'b00;
    localparam logic [1:0] MODE_RISING  = 2'b01;
    localparam logic [1:0] MODE_FALLING = 2'b10;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync;
    logic [NUM_CH-1:0] stable_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: stage 0 captures the raw asynchronous levels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in_signal;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

`ifdef AIDAN_MCNAY_EDGE_DETECT_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // Debounce filter: accept a new level only after it has disagreed with
    // stable for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            stable <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable[i] <= sync[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    // Unfiltered build: the accepted level is simply the synchronised level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= '0;
        end else begin
            stable <= sync;
        end
    end
`endif

    // Delayed copy of the accepted level used to spot transitions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    // Edge qualification: mode is applied live so a mode change affects only
    // which transitions are reported, never the filter itself
    always_comb begin
        pulse = '0;
        case (mode)
            MODE_ANY:     pulse = stable ^ stable_d;
            MODE_RISING:  pulse = stable & ~stable_d;
            MODE_FALLING: pulse = ~stable & stable_d;
            default:      pulse = '0;
        endcase
    end

    // Sticky event flags: a new event beats a simultaneous clear, and overflow
    // marks an event arriving while a previous one is still unacknowledged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= pulse | (pending & ~clear);
            overflow <= (pulse & pending & ~clear) | (overflow & ~clear);
        end
    end

endmodule

// File: tb/tb_aidan_mcnay_edge_detect_multi.sv
// tb_aidan_mcnay_edge_detect_multi
// Directed bench with a per-cycle behavioural model of the conditioner.
// Honours AIDAN_MCNAY_EDGE_DETECT_DEBOUNCE_EN the same way as the design.
module tb_aidan_mcnay_edge_detect_multi;

    localparam int NUM_CH = 4;
    localparam int SYNC   = 2;
    localparam int DEB    = 4;
`ifdef AIDAN_MCNAY_EDGE_DETECT_DEBOUNCE_EN
    localparam int EFF_DEB = DEB;
`else
    localparam int EFF_DEB = 1;
`endif
    localparam int LAT = SYNC + EFF_DEB;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] in_signal;
    logic [1:0]        mode;
    logic [NUM_CH-1:0] clear;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] overflow;
    logic [NUM_CH-1:0] stable;

    int compared   = 0;
    int mismatched = 0;

    aidan_mcnay_edge_detect_multi #(
        .NUM_CH(NUM_CH),
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_signal(in_signal),
        .mode(mode),
        .clear(clear),
        .pulse(pulse),
        .pending(pending),
        .overflow(overflow),
        .stable(stable)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Behavioural model: raw samples are delayed SYNC edges, then a level is
    // accepted once the last EFF_DEB delayed samples all disagree with it
    logic [NUM_CH-1:0] in_q [$];
    logic [NUM_CH-1:0] hist_q [$];
    logic [NUM_CH-1:0] stable_m = '0;
    logic [NUM_CH-1:0] prev_m = '0;
    logic [NUM_CH-1:0] pend_m = '0;
    logic [NUM_CH-1:0] ovf_m = '0;
    bit                model_valid = 1'b0;

    function automatic logic [NUM_CH-1:0] modelPulse(input logic [1:0] m);
        logic [NUM_CH-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (stable_m[i] != prev_m[i]) begin
                if (m == 2'b00) res[i] = 1'b1;
                else if (m == 2'b01 && stable_m[i]) res[i] = 1'b1;
                else if (m == 2'b10 && !stable_m[i]) res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    // Advance the model at every rising edge
    always @(posedge clk) begin
        logic [NUM_CH-1:0] p;
        logic [NUM_CH-1:0] s;
        bit all_differ;
        if (!rst_n) begin
            stable_m = '0;
            prev_m   = '0;
            pend_m   = '0;
            ovf_m    = '0;
            in_q.delete();
            hist_q.delete();
            for (int k = 0; k < SYNC; k++) in_q.push_back('0);
            model_valid = 1'b1;
        end else if (model_valid) begin
            p = modelPulse(mode);
            for (int i = 0; i < NUM_CH; i++) begin
                if (p[i]) begin
                    if (pend_m[i] && !clear[i]) ovf_m[i] = 1'b1;
                    if (clear[i]) ovf_m[i] = 1'b0;
                    pend_m[i] = 1'b1;
                end else if (clear[i]) begin
                    pend_m[i] = 1'b0;
                    ovf_m[i]  = 1'b0;
                end
            end
            prev_m = stable_m;
            s = in_q.pop_front();
            in_q.push_back(in_signal);
            hist_q.push_back(s);
            if (hist_q.size() > EFF_DEB) void'(hist_q.pop_front());
            if (hist_q.size() == EFF_DEB) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    all_differ = 1'b1;
                    foreach (hist_q[k]) if (hist_q[k][i] == stable_m[i]) all_differ = 1'b0;
                    if (all_differ) stable_m[i] = ~stable_m[i];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare DUT against model on every falling edge once reset has been seen
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("stable",   32'(stable),   32'(stable_m));
            checkOutput("pulse",    32'(pulse),    32'(modelPulse(mode)));
            checkOutput("pending",  32'(pending),  32'(pend_m));
            checkOutput("overflow", 32'(overflow), 32'(ovf_m));
        end
    end

    task automatic applyStimulus(input logic [NUM_CH-1:0] in_v, input logic [1:0] m,
                                 input logic [NUM_CH-1:0] clr);
        in_signal = in_v;
        mode      = m;
        clear     = clr;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic countPulses(input int bit_idx, input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            step(1);
            if (pulse[bit_idx]) cnt++;
        end
    endtask

    // Directed scenario sequence
    initial begin
        int cnt;
        bit found;

        rst_n = 1'b0;
        applyStimulus(4'b0000, 2'b00, 4'b0000);
        step(2);
        checkOutput("reset_stable",   32'(stable),   32'h0);
        checkOutput("reset_pulse",    32'(pulse),    32'h0);
        checkOutput("reset_pending",  32'(pending),  32'h0);
        checkOutput("reset_overflow", 32'(overflow), 32'h0);
        rst_n = 1'b1;
        step(1);

        // ch0 rising edge latency
        applyStimulus(4'b0001, 2'b00, 4'b0000);
        step(LAT - 1);
        checkOutput("rise_stable_early", 32'(stable), 32'h0);
        step(1);
        checkOutput("rise_stable",  32'(stable),  32'h1);
        checkOutput("rise_pulse",   32'(pulse),   32'h1);
        checkOutput("rise_pend_pre", 32'(pending), 32'h0);
        step(1);
        checkOutput("rise_pulse_end", 32'(pulse),   32'h0);
        checkOutput("rise_pending",   32'(pending), 32'h1);

        // ch1 three-cycle glitch
        applyStimulus(4'b0011, 2'b00, 4'b0000);
        step(3);
        applyStimulus(4'b0001, 2'b00, 4'b0000);
        step(12);
        checkOutput("glitch_stable", 32'(stable), 32'h1);
`ifdef AIDAN_MCNAY_EDGE_DETECT_DEBOUNCE_EN
        checkOutput("glitch_pending", 32'(pending), 32'h1);
`else
        checkOutput("glitch_pending", 32'(pending), 32'h3);
`endif

        applyStimulus(4'b0001, 2'b00, 4'b1111);
        step(1);
        applyStimulus(4'b0001, 2'b00, 4'b0000);
        checkOutput("clear_all_pending",  32'(pending),  32'h0);
        checkOutput("clear_all_overflow", 32'(overflow), 32'h0);

        // ch2 mode selection
        applyStimulus(4'b0101, 2'b01, 4'b0000);
        countPulses(2, 12, cnt);
        applyStimulus(4'b0001, 2'b01, 4'b0000);
        begin
            int c2;
            countPulses(2, 12, c2);
            checkOutput("mode_rising_count", 32'(cnt + c2), 32'd1);
        end
        applyStimulus(4'b0101, 2'b10, 4'b0000);
        countPulses(2, 12, cnt);
        applyStimulus(4'b0001, 2'b10, 4'b0000);
        begin
            int c2;
            countPulses(2, 12, c2);
            checkOutput("mode_falling_count", 32'(cnt + c2), 32'd1);
        end
        checkOutput("mode_pending",  32'(pending),  32'h4);
        checkOutput("mode_overflow", 32'(overflow), 32'h4);
        applyStimulus(4'b0101, 2'b11, 4'b0000);
        countPulses(2, 12, cnt);
        applyStimulus(4'b0001, 2'b11, 4'b0000);
        begin
            int c2;
            countPulses(2, 12, c2);
            checkOutput("mode_disabled_count", 32'(cnt + c2), 32'd0);
        end
        applyStimulus(4'b0001, 2'b00, 4'b1111);
        step(1);

        // ch3 overflow and clear handling
        applyStimulus(4'b1001, 2'b00, 4'b0000);
        step(12);
        applyStimulus(4'b0001, 2'b00, 4'b0000);
        step(12);
        checkOutput("ovf_pending",  32'(pending),  32'h8);
        checkOutput("ovf_overflow", 32'(overflow), 32'h8);
        applyStimulus(4'b0001, 2'b00, 4'b1000);
        step(1);
        applyStimulus(4'b0001, 2'b00, 4'b0000);
        checkOutput("clr3_pending",  32'(pending),  32'h0);
        checkOutput("clr3_overflow", 32'(overflow), 32'h0);

        applyStimulus(4'b1001, 2'b00, 4'b0000);
        step(12);
        applyStimulus(4'b0001, 2'b00, 4'b0000);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (pulse[3]) begin
                found = 1'b1;
                clear = 4'b1000;
            end
        end
        checkOutput("coinc_found", 32'(found), 32'd1);
        step(1);
        clear = 4'b0000;
        checkOutput("coinc_pending",  32'(pending),  32'h8);
        checkOutput("coinc_overflow", 32'(overflow), 32'h0);

        // Reset mid-debounce with pending set, inputs held high
        applyStimulus(4'b0011, 2'b00, 4'b0000);
        step(SYNC + 2);
        rst_n = 1'b0;
        step(1);
        checkOutput("rst2_stable",   32'(stable),   32'h0);
        checkOutput("rst2_pulse",    32'(pulse),    32'h0);
        checkOutput("rst2_pending",  32'(pending),  32'h0);
        checkOutput("rst2_overflow", 32'(overflow), 32'h0);
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (pulse[0]) found = 1'b1;
        end
        checkOutput("rst2_rise_found", 32'(found), 32'd1);
        step(3);
        checkOutput("rst2_stable_after", 32'(stable),  32'h3);
        checkOutput("rst2_pending_after", 32'(pending), 32'h3);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
